// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target.
//   I2C_ADDR_PN532    - default 7-bit bus address of the target
//   i2c_slave_state_t - protocol state encoding used by i2c_slave
package i2c_pkg;

    localparam logic [6:0] I2C_ADDR_PN532 = 7'h24;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_slave_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: brings one asynchronous bus line into the clk domain and flags its edges.
//   i_clk, i_rst_n - system clock, asynchronous active-low reset
//   i_in           - asynchronous bus line
//   o_level        - synchronized level
//   o_rise/o_fall  - one-clk pulses on synchronized rising/falling edges
// Flops reset to 1 so an idle (pulled-up) bus produces no edge when reset is released.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with a 7-bit address, byte write and byte read.
//   clk, reset_n - system clock, asynchronous active-low reset
//   scl          - bus clock (never stretched)
//   sda          - open-drain bus data (driven 0 or released)
//   tx_data      - byte returned on a read, fetched after each tx_req pulse
//   rx_data      - last byte written by the master, rx_valid pulses on update
//   tx_req       - pulse asking for the next tx_data
//   rw           - R/W bit of the last matched address (1 = read)
//   busy         - addressed transfer in progress
//   stop_det     - pulse on any STOP seen on the bus
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = I2C_ADDR_PN532,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       stop_det
);

    logic w_scl_level, w_scl_rise, w_scl_fall;
    logic w_sda_level, w_sda_rise, w_sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_in    (scl),
        .o_level (w_scl_level),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_in    (sda),
        .o_level (w_sda_level),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    logic w_start, w_stop;
    assign w_start = w_sda_fall & w_scl_level;
    assign w_stop  = w_sda_rise & w_scl_level;

    i2c_slave_state_t r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    // Set on the SCL rise of an ACK slot: separates the fall that opens the slot
    // from the fall that closes it.
    logic       r_ack_clk, w_ack_clk_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_tx_req, w_tx_req_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_stop_det, w_stop_det_nxt;

    // Byte completed by the bit sampled on the current SCL rise.
    logic [7:0] w_byte;
    assign w_byte = {r_shift[6:0], w_sda_level};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_ack_clk  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_stop_det <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_ack_clk  <= w_ack_clk_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_rw       <= w_rw_nxt;
            r_busy     <= w_busy_nxt;
            r_stop_det <= w_stop_det_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_sda_oe_nxt   = r_sda_oe;
        w_ack_clk_nxt  = r_ack_clk;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_rw_nxt       = r_rw;
        w_busy_nxt     = r_busy;
        w_stop_det_nxt = 1'b0;

        if (w_stop) begin
            w_state_nxt    = IDLE;
            w_sda_oe_nxt   = 1'b0;
            w_busy_nxt     = 1'b0;
            w_stop_det_nxt = 1'b1;
        end else if (w_start) begin
            w_state_nxt   = ADDR;
            w_bit_cnt_nxt = 3'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            unique case (r_state)
                IDLE, WAIT_STOP: begin
                end
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte[7:1] == SLAVE_ADDR) begin
                                w_rw_nxt      = w_byte[0];
                                w_busy_nxt    = 1'b1;
                                w_ack_clk_nxt = 1'b0;
                                w_state_nxt   = ADDR_ACK;
                            end else begin
                                w_state_nxt = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_clk_nxt = 1'b1;
                        w_tx_req_nxt  = r_rw;
                    end else if (w_scl_fall) begin
                        if (!r_ack_clk) begin
                            w_sda_oe_nxt = 1'b1;
                        end else if (r_rw) begin
                            // Shift holds the bits still to send after the MSB.
                            w_shift_nxt  = {tx_data[6:0], 1'b0};
                            w_sda_oe_nxt = ~tx_data[7];
                            w_state_nxt  = RD_BYTE;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rx_data_nxt  = w_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_ack_clk_nxt  = 1'b0;
                            w_state_nxt    = WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_clk_nxt = 1'b1;
                    end else if (w_scl_fall) begin
                        w_sda_oe_nxt = !r_ack_clk;
                        if (r_ack_clk) begin
                            w_state_nxt = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_ack_clk_nxt = 1'b0;
                            w_state_nxt   = RD_ACK;
                        end
                    end else if (w_scl_fall) begin
                        w_sda_oe_nxt = ~r_shift[7];
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda_level) begin
                            w_ack_clk_nxt = 1'b1;
                            w_tx_req_nxt  = 1'b1;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = WAIT_STOP;
                        end
                    end else if (w_scl_fall) begin
                        if (!r_ack_clk) begin
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_shift_nxt  = {tx_data[6:0], 1'b0};
                            w_sda_oe_nxt = ~tx_data[7];
                            w_state_nxt  = RD_BYTE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign sda      = r_sda_oe ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign rw       = r_rw;
    assign busy     = r_busy;
    assign stop_det = r_stop_det;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bus-level bench for i2c_slave. A bit-banged master drives SCL/SDA,
// pulse monitors count DUT strobes, directed table vectors and hand sequences cover
// the corner cases, and a random transaction stream is checked against a
// transaction-level model of the target.
module tb_i2c_slave;

    localparam int Q = 8;  // clk cycles per quarter of an SCL bit

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl   = 1'b1;
    logic       m_sda   = 1'b1;
    logic [7:0] tx_data = 8'h00;
    tri1        sda;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, rw, busy, stop_det;

    assign sda = m_sda ? 1'bz : 1'b0;

    always #10 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h24), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (m_scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .rw       (rw),
        .busy     (busy),
        .stop_det (stop_det)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Strobe monitors, sampled away from the active edge.
    int   rxv_cnt = 0, txr_cnt = 0, stop_cnt = 0, busy_cnt = 0;
    int   overlap_cnt = 0, drive_viol = 0;
    logic prev_drv = 1'b0, prev_scl = 1'b1, prev_rst = 1'b0;
    logic slave_drv;
    assign slave_drv = (sda === 1'b0) && m_sda;

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (tx_req) txr_cnt <= txr_cnt + 1;
        if (stop_det) stop_cnt <= stop_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (rx_valid && tx_req) overlap_cnt <= overlap_cnt + 1;
        // The target may only change its drive while SCL is low.
        if (reset_n && prev_rst && m_scl && prev_scl && (slave_drv != prev_drv))
            drive_viol <= drive_viol + 1;
        prev_drv <= slave_drv;
        prev_scl <= m_scl;
        prev_rst <= reset_n;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: bench did not reach its summary within the cycle budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    logic bus_bit;

    task automatic hq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic clock_bit(input logic b);
        m_sda = b;
        hq();
        m_scl = 1'b1;
        hq();
        bus_bit = sda;
        hq();
        m_scl = 1'b0;
        hq();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        hq();
        m_scl = 1'b1;
        hq();
        m_sda = 1'b0;
        hq();
        m_scl = 1'b0;
        hq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        hq();
        m_scl = 1'b1;
        hq();
        m_sda = 1'b1;
        hq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic [7:0] echo;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(b[i]);
            echo[i] = bus_bit;
        end
        check("wr_echo", 32'(echo), 32'(b));
        clock_bit(1'b1);
        ack = bus_bit;
    endtask

    task automatic read_byte(input logic nack, input logic [7:0] next_tx,
                             output logic [7:0] val, output logic ackline);
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1);
            val[i] = bus_bit;
        end
        if (!nack) tx_data = next_tx;
        clock_bit(nack);
        ackline = bus_bit;
    endtask

    typedef struct {
        string      name;
        logic [6:0] addr;
        logic       rd;
        logic [7:0] data;      // byte written, or tx_data offered on a read
        logic       exp_ack;   // bus level in the address ACK slot
        logic [7:0] exp_read;
        int         exp_rxv;
        int         exp_txr;
        logic       exp_busy;  // busy just before STOP
        logic [7:0] exp_rx;    // rx_data after STOP
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       a, al, acked, use_stop;
        logic [7:0] got, exp_rx;
        logic [6:0] addr;
        logic       rd, exp_rw;
        logic [7:0] bytes[3];
        int         n, rxv0, txr0, stp0, bsy0;

        vecs[0] = '{"wr24",  7'h24, 1'b0, 8'hA5, 1'b0, 8'h00, 1, 0, 1'b1, 8'hA5};
        vecs[1] = '{"rd24",  7'h24, 1'b1, 8'h3C, 1'b0, 8'h3C, 0, 1, 1'b0, 8'hA5};
        vecs[2] = '{"wr25",  7'h25, 1'b0, 8'h5A, 1'b1, 8'h00, 0, 0, 1'b0, 8'hA5};
        vecs[3] = '{"gcall", 7'h00, 1'b0, 8'h5A, 1'b1, 8'h00, 0, 0, 1'b0, 8'hA5};
        vecs[4] = '{"wr24z", 7'h24, 1'b0, 8'h00, 1'b0, 8'h00, 1, 0, 1'b1, 8'h00};

        // Reset values while reset is held.
        repeat (4) @(posedge clk);
        #1;
        check("rst_sda", 32'(sda), 32'(1'b1));
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_strobes", 32'({rx_valid, tx_req, stop_det}), 32'h0);
        check("rst_rw_busy", 32'({rw, busy}), 32'h0);
        reset_n = 1'b1;
        hq();

        foreach (vecs[v]) begin
            rxv0 = rxv_cnt; txr0 = txr_cnt; stp0 = stop_cnt; bsy0 = busy_cnt;
            if (vecs[v].rd) tx_data = vecs[v].data;
            i2c_start();
            write_byte({vecs[v].addr, vecs[v].rd}, a);
            check({vecs[v].name, "_addr_ack"}, 32'(a), 32'(vecs[v].exp_ack));
            if (vecs[v].exp_ack == 1'b0) begin
                check({vecs[v].name, "_rw"}, 32'(rw), 32'(vecs[v].rd));
                if (vecs[v].rd) begin
                    read_byte(1'b1, 8'h00, got, al);
                    check({vecs[v].name, "_read"}, 32'(got), 32'(vecs[v].exp_read));
                    check({vecs[v].name, "_released"}, 32'(al), 32'(1'b1));
                end else begin
                    write_byte(vecs[v].data, a);
                    check({vecs[v].name, "_data_ack"}, 32'(a), 32'(1'b0));
                end
            end
            check({vecs[v].name, "_busy"}, 32'(busy), 32'(vecs[v].exp_busy));
            i2c_stop();
            hq();
            check({vecs[v].name, "_rxv"}, 32'(rxv_cnt - rxv0), 32'(vecs[v].exp_rxv));
            check({vecs[v].name, "_txr"}, 32'(txr_cnt - txr0), 32'(vecs[v].exp_txr));
            check({vecs[v].name, "_stop_det"}, 32'(stop_cnt - stp0), 32'd1);
            check({vecs[v].name, "_busy_end"}, 32'(busy), 32'(1'b0));
            check({vecs[v].name, "_busy_seen"}, 32'(busy_cnt != bsy0),
                  32'(vecs[v].exp_ack == 1'b0));
            check({vecs[v].name, "_rx_data"}, 32'(rx_data), 32'(vecs[v].exp_rx));
        end

        // Write 0x11, repeated START, read 0x80 with NACK.
        rxv0 = rxv_cnt; txr0 = txr_cnt; stp0 = stop_cnt;
        i2c_start();
        write_byte(8'h48, a);
        check("rs_wr_addr_ack", 32'(a), 32'(1'b0));
        write_byte(8'h11, a);
        check("rs_wr_data_ack", 32'(a), 32'(1'b0));
        tx_data = 8'h80;
        i2c_start();
        write_byte(8'h49, a);
        check("rs_rd_addr_ack", 32'(a), 32'(1'b0));
        check("rs_rw", 32'(rw), 32'(1'b1));
        read_byte(1'b1, 8'h00, got, al);
        check("rs_read", 32'(got), 32'h80);
        check("rs_released", 32'(al), 32'(1'b1));
        check("rs_busy_nack", 32'(busy), 32'(1'b0));
        i2c_stop();
        hq();
        check("rs_rx_data", 32'(rx_data), 32'h11);
        check("rs_rxv", 32'(rxv_cnt - rxv0), 32'd1);
        check("rs_txr", 32'(txr_cnt - txr0), 32'd1);
        check("rs_stop", 32'(stop_cnt - stp0), 32'd1);

        // STOP after four data bits: partial byte is dropped.
        rxv0 = rxv_cnt; stp0 = stop_cnt;
        i2c_start();
        write_byte(8'h48, a);
        check("part_addr_ack", 32'(a), 32'(1'b0));
        clock_bit(1'b1); clock_bit(1'b0); clock_bit(1'b1); clock_bit(1'b1);
        i2c_stop();
        hq();
        check("part_rxv", 32'(rxv_cnt - rxv0), 32'd0);
        check("part_stop", 32'(stop_cnt - stp0), 32'd1);
        check("part_busy", 32'(busy), 32'(1'b0));
        check("part_rx_data", 32'(rx_data), 32'h11);

        // Reset while the target is pulling SDA low in the address ACK slot.
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(i == 6 || i == 3);
        m_sda = 1'b1;
        hq();
        m_scl = 1'b1;
        hq();
        check("ack_before_reset", 32'(sda), 32'(1'b0));
        reset_n = 1'b0;
        #1;
        check("reset_sda_release", 32'(sda), 32'(1'b1));
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_busy", 32'(busy), 32'(1'b0));
        hq();
        reset_n = 1'b1;
        hq();
        m_scl = 1'b0;
        hq();
        // Tail of the interrupted transfer looks like a matching address; it must be ignored.
        rxv0 = rxv_cnt; bsy0 = busy_cnt;
        for (int i = 7; i >= 0; i--) clock_bit(i == 6 || i == 3);
        clock_bit(1'b1);
        check("post_reset_no_ack", 32'(bus_bit), 32'(1'b1));
        check("post_reset_busy", 32'(busy_cnt - bsy0), 32'd0);
        i2c_start();
        write_byte(8'h48, a);
        check("post_reset_addr_ack", 32'(a), 32'(1'b0));
        write_byte(8'h77, a);
        check("post_reset_data_ack", 32'(a), 32'(1'b0));
        i2c_stop();
        hq();
        check("post_reset_rx_data", 32'(rx_data), 32'h77);
        check("post_reset_rxv", 32'(rxv_cnt - rxv0), 32'd1);

        // Random transactions against a transaction-level model of the target.
        exp_rx = 8'h77;
        exp_rw = 1'b0;
        for (int t = 0; t < 16; t++) begin
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h24;
            rd   = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(1, 3));
            for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom);
            use_stop = (t == 15) || ($urandom_range(0, 1) == 1);
            acked = (addr == 7'h24);
            rxv0 = rxv_cnt; txr0 = txr_cnt; stp0 = stop_cnt;
            if (rd) tx_data = bytes[0];
            i2c_start();
            write_byte({addr, rd}, a);
            check("rnd_addr_ack", 32'(a), 32'(!acked));
            if (acked) begin
                exp_rw = rd;
                for (int k = 0; k < n; k++) begin
                    if (rd) begin
                        read_byte(k == n - 1, (k < n - 1) ? bytes[(k + 1) % 3] : 8'h00, got, al);
                        check("rnd_read", 32'(got), 32'(bytes[k]));
                        if (k == n - 1) check("rnd_read_release", 32'(al), 32'(1'b1));
                    end else begin
                        write_byte(bytes[k], a);
                        check("rnd_data_ack", 32'(a), 32'(1'b0));
                        exp_rx = bytes[k];
                    end
                end
            end
            check("rnd_busy", 32'(busy), 32'(acked && !rd));
            check("rnd_rxv", 32'(rxv_cnt - rxv0), 32'((acked && !rd) ? n : 0));
            check("rnd_txr", 32'(txr_cnt - txr0), 32'((acked && rd) ? n : 0));
            check("rnd_rx_data", 32'(rx_data), 32'(exp_rx));
            check("rnd_rw", 32'(rw), 32'(exp_rw));
            if (use_stop) begin
                i2c_stop();
                hq();
                check("rnd_stop", 32'(stop_cnt - stp0), 32'd1);
                check("rnd_busy_end", 32'(busy), 32'(1'b0));
            end
        end

        check("no_rxv_txr_overlap", 32'(overlap_cnt), 32'd0);
        check("drive_only_scl_low", 32'(drive_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
